msp430_per_mailbox: RTL and testbench

Peripheral-bus responder (slave) for the MSP430 core's per_addr/per_din/per_we/per_en/per_dout interface. It provides a bidirectional word mailbox between CPU software and an external agent such as a debug host or companion core. There is one TX FIFO (CPU to stream) and one RX FIFO (stream to CPU), each with a valid/ready stream port, plus a level interrupt. The block sits on the peripheral bus next to the other peripherals, and its per_dout is OR-combined with theirs.

---
 rtl/msp430_mailbox_pkg.sv | 29 ++
 rtl/msp430_mailbox_fifo.sv | 68 ++++++
 rtl/msp430_per_mailbox.sv | 144 ++++++++++++++
 tb/tb_msp430_per_mailbox.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msp430_mailbox_pkg.sv
// Shared definitions for the MSP430 peripheral mailbox.
// Register map indices, CTRL/STATUS bit positions, sizing helper.
package msp430_mailbox_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_IE = 1;
  localparam int CTRL_TX_IE = 2;
  localparam int CTRL_FLUSH = 3;

  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_RX_UNF    = 5;
  localparam int ST_TXCNT_LSB = 8;
  localparam int ST_RXCNT_LSB = 12;

  // count must hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/msp430_mailbox_fifo.sv
// Power-of-two word FIFO with head output and flush.
// Push when full and pop when empty are ignored.
module msp430_mailbox_fifo
  import msp430_mailbox_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rp_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (push_ok & ~pop_ok)
      cnt_d = cnt_q + CW'(1);
    else if (pop_ok & ~push_ok)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push_ok) begin
          mem_q[wp_q] <= din;
          wp_q        <= wp_q + PW'(1);
        end
        if (pop_ok)
          rp_q <= rp_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/msp430_per_mailbox.sv
// MSP430 peripheral-bus word mailbox: CPU<->stream TX/RX FIFOs.
// Four word registers: CTRL, STATUS, TXDATA, RXDATA.
module msp430_per_mailbox
  import msp430_mailbox_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190,
  parameter int          DEPTH     = 4,
  parameter int          DW        = 16
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic [1:0]  per_we,
  input  logic        per_en,
  output logic [15:0] per_dout,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int CW = cnt_w(DEPTH);

  logic          sel, wr, rd;
  logic [1:0]    idx;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          irq_q;
  logic          flush;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [DW-1:0] tx_din, tx_head;
  logic [CW-1:0] tx_cnt;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [DW-1:0] rx_head;
  logic [CW-1:0] rx_cnt;
  logic [15:0]   status, rdata;

  assign sel = per_en & (per_addr[13:2] == BASE_ADDR[14:3]);
  assign idx = per_addr[1:0];
  assign wr  = sel & (|per_we);
  assign rd  = sel & ~(|per_we);

  assign flush = wr & (idx == REG_CTRL) & per_we[0]
               & per_din[CTRL_FLUSH];

  assign tx_push  = wr & (idx == REG_TXDATA);
  assign tx_din   = {per_we[1] ? per_din[15:8] : 8'h00,
                     per_we[0] ? per_din[7:0]  : 8'h00};
  assign tx_valid = ctrl_q[CTRL_TX_EN] & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_data  = tx_head;

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd & (idx == REG_RXDATA);

  assign irq = irq_q;

  msp430_mailbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx (
    .clk   (mclk),
    .rst_n (reset_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (tx_din),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  msp430_mailbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx (
    .clk   (mclk),
    .rst_n (reset_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  // a new overflow/underflow wins over a same-cycle clear
  always_comb begin
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (wr && idx == REG_CTRL && per_we[0])
      ctrl_d = per_din[2:0];
    if (wr && idx == REG_STATUS && per_we[0]) begin
      if (per_din[ST_TX_OVF]) ovf_d = 1'b0;
      if (per_din[ST_RX_UNF]) unf_d = 1'b0;
    end
    if (tx_push & tx_full)  ovf_d = 1'b1;
    if (rx_pop & rx_empty)  unf_d = 1'b1;
  end

  always_comb begin
    status = '0;
    status[ST_RX_NEMPTY] = ~rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_OVF]    = ovf_q;
    status[ST_RX_UNF]    = unf_q;
    status[ST_TXCNT_LSB +: 4] = 4'(tx_cnt);
    status[ST_RXCNT_LSB +: 4] = 4'(rx_cnt);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (idx == REG_CTRL):   rdata = {13'b0, ctrl_q};
      (idx == REG_STATUS): rdata = status;
      (idx == REG_TXDATA): rdata = '0;
      (idx == REG_RXDATA): rdata = rx_empty ? '0 : rx_head;
    endcase
    per_dout = rd ? rdata : '0;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      irq_q  <= (ctrl_q[CTRL_RX_IE] & ~rx_empty)
              | (ctrl_q[CTRL_TX_IE] & tx_empty);
    end
  end

endmodule

// File: tb/tb_msp430_per_mailbox.sv
// Bench for msp430_per_mailbox: queue model checked every cycle
// plus directed vectors with literal expectations.
module tb_msp430_per_mailbox;

  localparam int          DEPTH = 4;
  localparam logic [14:0] BASE  = 15'h0190;
  localparam logic [13:0] WBASE = 14'h00C8;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic [1:0]  per_we = '0;
  logic        per_en = 1'b0;
  logic [15:0] per_dout;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 mclk = ~mclk;

  msp430_per_mailbox #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .DW        (16)
  ) dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_we   (per_we),
    .per_en   (per_en),
    .per_dout (per_dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // model: queues and flags
  logic [15:0] mtx[$];
  logic [15:0] mrx[$];
  bit m_txen = 0, m_rxie = 0, m_txie = 0;
  bit m_ovf = 0, m_unf = 0, m_irq = 0;

  function automatic logic [15:0] exp_dout();
    logic [15:0] v;
    bit s;
    s = per_en && (per_addr[13:2] == BASE[14:3]) && (per_we == 2'b00);
    v = 16'h0;
    if (s) begin
      case (per_addr[1:0])
        2'd0: v = 16'(m_txen) | 16'(m_rxie) << 1 | 16'(m_txie) << 2;
        2'd1: begin
          v = 16'(mrx.size() > 0) | 16'(mrx.size() == DEPTH) << 1
            | 16'(mtx.size() == 0) << 2 | 16'(mtx.size() == DEPTH) << 3
            | 16'(m_ovf) << 4 | 16'(m_unf) << 5
            | 16'(mtx.size()) << 8 | 16'(mrx.size()) << 12;
        end
        2'd2: v = 16'h0;
        default: v = (mrx.size() > 0) ? mrx[0] : 16'h0;
      endcase
    end
    return v;
  endfunction

  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      mtx.delete();
      mrx.delete();
      {m_txen, m_rxie, m_txie, m_ovf, m_unf, m_irq} = '0;
    end else begin
      bit s, w, r, fl, txpop, txpush, ovf, rxpush, rxpop, unf, nirq;
      logic [1:0] ix;
      logic [15:0] word;
      s  = per_en && (per_addr[13:2] == BASE[14:3]);
      ix = per_addr[1:0];
      w  = s && (per_we != 2'b00);
      r  = s && (per_we == 2'b00);
      fl = w && ix == 2'd0 && per_we[0] && per_din[3];
      txpop  = m_txen && mtx.size() > 0 && tx_ready;
      txpush = w && ix == 2'd2;
      ovf    = txpush && mtx.size() == DEPTH;
      rxpush = rx_valid && mrx.size() < DEPTH;
      rxpop  = r && ix == 2'd3;
      unf    = rxpop && mrx.size() == 0;
      nirq   = (m_rxie && mrx.size() > 0) || (m_txie && mtx.size() == 0);
      word = {per_we[1] ? per_din[15:8] : 8'h00,
              per_we[0] ? per_din[7:0] : 8'h00};
      if (fl) begin
        mtx.delete();
        mrx.delete();
      end else begin
        if (txpop) void'(mtx.pop_front());
        if (txpush && !ovf) mtx.push_back(word);
        if (rxpop && !unf) void'(mrx.pop_front());
        if (rxpush) mrx.push_back(rx_data);
      end
      if (w && ix == 2'd1 && per_we[0]) begin
        if (per_din[4]) m_ovf = 0;
        if (per_din[5]) m_unf = 0;
      end
      if (ovf) m_ovf = 1;
      if (unf) m_unf = 1;
      if (w && ix == 2'd0 && per_we[0])
        {m_txie, m_rxie, m_txen} = per_din[2:0];
      m_irq = nirq;
    end
  end

  always @(negedge mclk) begin
    if (reset_n) begin
      bit tv;
      tv = m_txen && mtx.size() > 0;
      chk("m_per_dout", per_dout, exp_dout());
      chk("m_tx_valid", 16'(tx_valid), 16'(tv));
      if (tv) chk("m_tx_data", tx_data, mtx[0]);
      chk("m_rx_ready", 16'(rx_ready), 16'(mrx.size() < DEPTH));
      chk("m_irq", 16'(irq), 16'(m_irq));
    end
  end

  logic [15:0] txlog[$];
  always @(negedge mclk)
    if (reset_n && tx_valid && tx_ready) txlog.push_back(tx_data);

  logic [15:0] rx_src[$];
  initial begin : rxdrv
    bit a;
    forever begin
      @(negedge mclk);
      a = rx_valid && rx_ready;
      @(posedge mclk);
      #1;
      if (a && rx_src.size() > 0) void'(rx_src.pop_front());
      rx_valid = rx_src.size() > 0;
      rx_data  = rx_valid ? rx_src[0] : 16'h0;
    end
  end

  task automatic op(input bit en, input logic [1:0] ix,
                    input logic [1:0] we, input logic [15:0] d);
    @(posedge mclk);
    #1;
    per_en   = en;
    per_addr = WBASE + 14'(ix);
    per_we   = we;
    per_din  = d;
    @(negedge mclk);
  endtask

  task automatic wr(input logic [1:0] ix, input logic [15:0] d);
    op(1'b1, ix, 2'b11, d);
  endtask

  task automatic rd(input logic [1:0] ix, input logic [15:0] exp,
                    input string name);
    op(1'b1, ix, 2'b00, 16'h0);
    chk(name, per_dout, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 2'd0, 2'b00, 16'h0);
  endtask

  initial begin
    repeat (3) @(posedge mclk);
    #1 reset_n = 1'b1;
    @(negedge mclk);
    chk("rst_rx_ready", 16'(rx_ready), 16'h1);
    chk("rst_tx_valid", 16'(tx_valid), 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_tx_data", tx_data, 16'h0);
    rd(2'd1, 16'h0004, "rst_status");

    tx_ready = 1'b1;
    wr(2'd0, 16'h0001);
    wr(2'd2, 16'h1234);
    wr(2'd2, 16'hABCD);
    chk("tx_first_valid", 16'(tx_valid), 16'h1);
    chk("tx_first_data", tx_data, 16'h1234);
    idle(1);
    chk("tx_second_data", tx_data, 16'hABCD);
    idle(1);
    chk("tx_drop_valid", 16'(tx_valid), 16'h0);
    rd(2'd1, 16'h0004, "tx_drained_status");

    tx_ready = 1'b0;
    wr(2'd0, 16'h0000);
    txlog.delete();
    for (int i = 0; i < 5; i++) wr(2'd2, 16'h1000 + 16'(i));
    rd(2'd1, 16'h0418, "tx_full_ovf_status");
    wr(2'd1, 16'h0010);
    rd(2'd1, 16'h0408, "tx_ovf_cleared");
    tx_ready = 1'b1;
    wr(2'd0, 16'h0001);
    idle(6);
    chk("drain_count", 16'(txlog.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      if (txlog.size() > i)
        chk("drain_word", txlog[i], 16'h1000 + 16'(i));

    txlog.delete();
    op(1'b1, 2'd2, 2'b10, 16'h55AA);
    idle(2);
    chk("byte_wr_count", 16'(txlog.size()), 16'd1);
    if (txlog.size() > 0) chk("byte_wr_word", txlog[0], 16'h5500);
    wr(2'd0, 16'h0000);
    tx_ready = 1'b0;

    for (int i = 1; i <= 5; i++) rx_src.push_back(16'(i));
    idle(8);
    chk("rx_full_ready", 16'(rx_ready), 16'h0);
    rd(2'd1, 16'h4007, "rx_full_status");
    rd(2'd3, 16'd1, "rx_read1");
    rd(2'd3, 16'd2, "rx_read2");
    rd(2'd3, 16'd3, "rx_read3");
    rd(2'd3, 16'd4, "rx_read4");
    idle(2);
    rd(2'd3, 16'd5, "rx_read5");
    rd(2'd3, 16'h0000, "rx_empty_read");
    rd(2'd1, 16'h0024, "rx_unf_status");
    rd(2'd2, 16'h0000, "txdata_reads0");
    wr(2'd1, 16'h0020);

    wr(2'd0, 16'h0002);
    idle(1);
    chk("irq_idle", 16'(irq), 16'h0);
    rx_src.push_back(16'h0077);
    idle(1);
    idle(1);
    chk("irq_lag", 16'(irq), 16'h0);
    idle(1);
    chk("irq_set", 16'(irq), 16'h1);

    rx_src.push_back(16'h0088);
    wr(2'd0, 16'h000A);
    rd(2'd1, 16'h0004, "flush_status");
    idle(1);
    chk("irq_after_flush", 16'(irq), 16'h0);
    chk("flush_rx_ready", 16'(rx_ready), 16'h1);
    rd(2'd0, 16'h0002, "ctrl_readback");
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
